// File: rtl/core_pkg.sv
// Shared RV32I encodings for the single-cycle core: opcodes, funct fields,
// machine-mode CSR addresses and trap causes.
package core_pkg;

    typedef enum logic [6:0] {
        LOAD     = 7'b0000011,
        MISC_MEM = 7'b0001111,
        OP_IMM   = 7'b0010011,
        AUIPC    = 7'b0010111,
        STORE    = 7'b0100011,
        OP       = 7'b0110011,
        LUI      = 7'b0110111,
        BRANCH   = 7'b1100011,
        JALR     = 7'b1100111,
        JAL      = 7'b1101111,
        SYSTEM   = 7'b1110011
    } opcode_t;

    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL  = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR   = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_LB   = 3'd0, F3_LH   = 3'd1, F3_LW  = 3'd2, F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;
    localparam logic [2:0] F3_SB   = 3'd0, F3_SH   = 3'd1, F3_SW  = 3'd2;
    localparam logic [2:0] F3_PRIV = 3'd0, F3_CSR_BAD = 3'd4;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [11:0] MTVEC  = 12'h305;
    localparam logic [11:0] MEPC   = 12'h341;
    localparam logic [11:0] MCAUSE = 12'h342;

    localparam logic [11:0] SYS_ECALL  = 12'h000;
    localparam logic [11:0] SYS_EBREAK = 12'h001;
    localparam logic [11:0] SYS_MRET   = 12'h302;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/core_if.sv
// Fetch and data port bundle between the core datapath and its unified memory.
interface core_if;
    logic [15:0] fetch_addr;
    logic [31:0] fetch_data;
    logic [15:0] data_addr;
    logic [31:0] data_rdata;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;

    modport master (output fetch_addr, data_addr, data_wdata, data_be,
                    input  fetch_data, data_rdata);
    modport slave  (input  fetch_addr, data_addr, data_wdata, data_be,
                    output fetch_data, data_rdata);
endinterface

// File: rtl/core_memory.sv
// 64 KiB byte-addressed unified memory: combinational little-endian reads,
// byte-enabled synchronous writes, all addresses wrapping at 16 bits.
module memory (
    input logic   clk,
    core_if.slave bus
);
    logic [7:0] m [0:65535];

    assign bus.fetch_data = {m[bus.fetch_addr + 16'd3], m[bus.fetch_addr + 16'd2],
                             m[bus.fetch_addr + 16'd1], m[bus.fetch_addr]};
    assign bus.data_rdata = {m[bus.data_addr + 16'd3], m[bus.data_addr + 16'd2],
                             m[bus.data_addr + 16'd1], m[bus.data_addr]};

    // Lane i of the write data always lands at data_addr+i, so narrow stores need no shifting.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.data_be[i]) begin
                m[bus.data_addr + 16'(i)] <= bus.data_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/core.sv
// Single-cycle RV32I core: fetch, decode, execute and write back every clk,
// with a plain 4096-entry CSR array and ECALL/EBREAK/MRET trap handling.
module core
    import core_pkg::*;
(
    input logic clk,
    input logic rst
);
    core_if bus ();
    memory memory (.clk(clk), .bus(bus));

    logic [31:0] pc;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    logic [31:0] instr, imm_i, imm_b, imm_u, imm_j;
    logic [15:0] imm_s;
    opcode_t     opcode;
    logic [4:0]  rd, ra1, ra2;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [31:0] rv1, rv2, alu_b, alu_y, load_y, csr_old, csr_src, csr_new;
    logic [31:0] next_pc, rd_val, cause;
    logic [3:0]  be;
    logic        rd_we, csr_we, trap, taken;

    assign instr    = bus.fetch_data;
    assign opcode   = opcode_t'(instr[6:0]);
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign ra1      = instr[19:15];
    assign ra2      = instr[24:20];
    assign csr_addr = instr[31:20];
    assign imm_i    = sext12(instr[31:20]);
    assign imm_s    = {{4{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'b0};
    assign imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rv1      = (ra1 == 5'd0) ? 32'd0 : rs[ra1];
    assign rv2      = (ra2 == 5'd0) ? 32'd0 : rs[ra2];
    assign csr_old  = csr[csr_addr];

    assign bus.fetch_addr = pc[15:0];
    assign bus.data_addr  = (opcode == STORE) ? rv1[15:0] + imm_s : rv1[15:0] + imm_i[15:0];
    assign bus.data_wdata = rv2;
    assign bus.data_be    = rst ? be : 4'b0000;

    // Shared by OP and OP-IMM; bit 30 selects SUB (register form only) and SRA.
    always_comb begin
        alu_b = (opcode == OP) ? rv2 : imm_i;
        alu_y = 32'd0;
        case (funct3)
            F3_ADD:  alu_y = (opcode == OP && instr[30]) ? rv1 - alu_b : rv1 + alu_b;
            F3_SLL:  alu_y = rv1 << alu_b[4:0];
            F3_SLT:  alu_y = {31'b0, $signed(rv1) < $signed(alu_b)};
            F3_SLTU: alu_y = {31'b0, rv1 < alu_b};
            F3_XOR:  alu_y = rv1 ^ alu_b;
            F3_SR:   alu_y = instr[30] ? 32'($signed(rv1) >>> alu_b[4:0]) : rv1 >> alu_b[4:0];
            F3_OR:   alu_y = rv1 | alu_b;
            F3_AND:  alu_y = rv1 & alu_b;
            default: alu_y = 32'd0;
        endcase
    end

    always_comb begin
        load_y = bus.data_rdata;
        taken  = 1'b0;
        case (funct3)
            F3_LB:   load_y = {{24{bus.data_rdata[7]}}, bus.data_rdata[7:0]};
            F3_LH:   load_y = {{16{bus.data_rdata[15]}}, bus.data_rdata[15:0]};
            F3_LBU:  load_y = {24'b0, bus.data_rdata[7:0]};
            F3_LHU:  load_y = {16'b0, bus.data_rdata[15:0]};
            default: load_y = bus.data_rdata;
        endcase
        case (funct3)
            F3_BEQ:  taken = (rv1 == rv2);
            F3_BNE:  taken = (rv1 != rv2);
            F3_BLT:  taken = ($signed(rv1) < $signed(rv2));
            F3_BGE:  taken = ($signed(rv1) >= $signed(rv2));
            F3_BLTU: taken = (rv1 < rv2);
            F3_BGEU: taken = (rv1 >= rv2);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc + 32'd4;
        rd_we   = 1'b0;
        rd_val  = alu_y;
        be      = 4'b0000;
        csr_we  = 1'b0;
        trap    = 1'b0;
        cause   = CAUSE_ECALL;
        csr_src = funct3[2] ? {27'b0, ra1} : rv1;
        case (funct3[1:0])
            2'b01:   csr_new = csr_src;
            2'b10:   csr_new = csr_old | csr_src;
            2'b11:   csr_new = csr_old & ~csr_src;
            default: csr_new = csr_old;
        endcase
        case (opcode)
            LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
            AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
            JAL:    begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j; end
            JALR:   begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = (rv1 + imm_i) & ~32'd1; end
            BRANCH: if (taken) next_pc = pc + imm_b;
            LOAD:   begin
                rd_we  = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
                rd_val = load_y;
            end
            STORE:  begin
                case (funct3)
                    F3_SB:   be = 4'b0001;
                    F3_SH:   be = 4'b0011;
                    F3_SW:   be = 4'b1111;
                    default: be = 4'b0000;
                endcase
            end
            OP_IMM, OP: rd_we = 1'b1;
            SYSTEM: begin
                if (funct3 == F3_PRIV) begin
                    case (csr_addr)
                        SYS_ECALL:  begin trap = 1'b1; next_pc = {csr[MTVEC][31:2], 2'b00}; end
                        SYS_EBREAK: begin
                            trap    = 1'b1;
                            cause   = CAUSE_EBREAK;
                            next_pc = {csr[MTVEC][31:2], 2'b00};
                        end
                        SYS_MRET:   next_pc = csr[MEPC];
                        default:    ;
                    endcase
                end else if (funct3 != F3_CSR_BAD) begin
                    rd_we  = 1'b1;
                    rd_val = csr_old;
                    csr_we = (funct3[1:0] == 2'b01) || (ra1 != 5'd0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
        end
    end

    // CSR storage is deliberately left out of reset so preloaded values survive.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (csr_we) csr[csr_addr] <= csr_new;
            if (trap) begin
                csr[MEPC]   <= pc;
                csr[MCAUSE] <= cause;
            end
        end
    end
endmodule

// File: tb/tb_core.sv
// Lockstep bench for core: directed programs from the test plan plus random
// programs, each cycle compared against an instruction-level reference model.
module tb_core;
    logic clk = 1'b0;
    logic rst = 1'b0;

    core dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int wp;

    logic [7:0]  mmem [0:65535];
    logic [31:0] mrs  [0:31];
    logic [31:0] mcsr [0:4095];
    logic [31:0] mpc;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, r2, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encI(input logic [31:0] imm, input logic [4:0] r1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [31:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                         input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] encB(input logic [31:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                         input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] encU(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm[19:0], rd, op};
    endfunction

    function automatic logic [31:0] encJ(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic [31:0] t;
        t = v << (32 - bits);
        return $signed(t) >>> (32 - bits);
    endfunction

    function automatic logic [31:0] modelWord(input logic [15:0] a);
        return {mmem[a + 16'd3], mmem[a + 16'd2], mmem[a + 16'd1], mmem[a]};
    endfunction

    function automatic logic [31:0] dutWord(input logic [15:0] a);
        return {dut.memory.m[a + 16'd3], dut.memory.m[a + 16'd2], dut.memory.m[a + 16'd1], dut.memory.m[a]};
    endfunction

    task automatic emit(input logic [31:0] w);
        for (int k = 0; k < 4; k++) mmem[wp + k] = w[8*k +: 8];
        wp += 4;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 65536; i++) mmem[i] = 8'h00;
        wp = 0;
    endtask

    // Architectural step: executes the instruction at mpc on the model state.
    task automatic modelStep(output int rdOut, output bit stored, output logic [15:0] stAddr);
        logic [31:0] ins, a, b, opB, res, ea, npc, old, src, raw;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  op;
        bit          wr, cond;
        int          n;
        ins = modelWord(mpc[15:0]);
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; r1 = ins[19:15]; r2 = ins[24:20];
        a = mrs[r1]; b = mrs[r2];
        npc = mpc + 4; res = 0; wr = 0; stored = 0; stAddr = 0;
        case (op)
            7'h37: begin wr = 1; res = ins & 32'hFFFFF000; end
            7'h17: begin wr = 1; res = mpc + (ins & 32'hFFFFF000); end
            7'h6f: begin wr = 1; res = mpc + 4;
                   npc = mpc + sx({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21); end
            7'h67: begin wr = 1; res = mpc + 4; npc = (a + sx(ins >> 20, 12)) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd4: cond = (int'(a) < int'(b));
                    3'd5: cond = (int'(a) >= int'(b));
                    3'd6: cond = (a < b);
                    3'd7: cond = (a >= b);
                    default: cond = 0;
                endcase
                if (cond) npc = mpc + sx({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            end
            7'h03: begin
                ea = a + sx(ins >> 20, 12);
                for (int k = 0; k < 4; k++) raw[8*k +: 8] = mmem[ea[15:0] + 16'(k)];
                wr = 1;
                case (f3)
                    3'd0: res = sx(raw & 32'hFF, 8);
                    3'd1: res = sx(raw & 32'hFFFF, 16);
                    3'd2: res = raw;
                    3'd4: res = raw & 32'hFF;
                    3'd5: res = raw & 32'hFFFF;
                    default: wr = 0;
                endcase
            end
            7'h23: begin
                ea = a + sx({ins[31:25], ins[11:7]}, 12);
                n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
                for (int k = 0; k < n; k++) mmem[ea[15:0] + 16'(k)] = b[8*k +: 8];
                stored = (n > 0);
                stAddr = ea[15:0];
            end
            7'h13, 7'h33: begin
                wr = 1;
                opB = (op == 7'h33) ? b : sx(ins >> 20, 12);
                case (f3)
                    3'd0: res = (op == 7'h33 && ins[30]) ? a - opB : a + opB;
                    3'd1: res = a << opB[4:0];
                    3'd2: res = (int'(a) < int'(opB)) ? 1 : 0;
                    3'd3: res = (a < opB) ? 1 : 0;
                    3'd4: res = a ^ opB;
                    3'd5: res = ins[30] ? 32'(int'(a) >>> opB[4:0]) : a >> opB[4:0];
                    3'd6: res = a | opB;
                    default: res = a & opB;
                endcase
            end
            7'h73: begin
                if (f3 == 0) begin
                    if (ins[31:20] == 12'h000 || ins[31:20] == 12'h001) begin
                        mcsr[12'h341] = mpc;
                        mcsr[12'h342] = (ins[31:20] == 12'h000) ? 11 : 3;
                        npc = mcsr[12'h305] & ~32'd3;
                    end else if (ins[31:20] == 12'h302) begin
                        npc = mcsr[12'h341];
                    end
                end else if (f3 != 4) begin
                    old = mcsr[ins[31:20]];
                    src = f3[2] ? 32'(r1) : a;
                    if (f3[1:0] == 2'b01) mcsr[ins[31:20]] = src;
                    else if (r1 != 0 && f3[1:0] == 2'b10) mcsr[ins[31:20]] = old | src;
                    else if (r1 != 0) mcsr[ins[31:20]] = old & ~src;
                    wr = 1; res = old;
                end
            end
            default: ;
        endcase
        rdOut = (wr && rd != 0) ? int'(rd) : 0;
        if (rdOut != 0) mrs[rd] = res;
        mpc = npc;
    endtask

    task automatic applyStimulus(input int cycles);
        int rdw;
        bit st;
        logic [15:0] sa;
        for (int c = 0; c < cycles; c++) begin
            modelStep(rdw, st, sa);
            @(posedge clk);
            #1;
            checkOutput("pc", dut.pc, mpc);
            if (rdw != 0) checkOutput($sformatf("x%0d", rdw), dut.rs[rdw], mrs[rdw]);
            if (st) checkOutput($sformatf("mem@%04h", sa), dutWord(sa), modelWord(sa));
        end
    endtask

    task automatic doReset();
        logic [31:0] acc;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 65536; i++) dut.memory.m[i] = mmem[i];
        repeat (2) @(posedge clk);
        #1;
        acc = 0;
        for (int i = 0; i < 32; i++) acc |= dut.rs[i];
        checkOutput("reset pc", dut.pc, 32'd0);
        checkOutput("reset regs", acc, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mpc = 0;
        for (int i = 0; i < 32; i++) mrs[i] = 0;
    endtask

    function automatic logic [31:0] randomInstr();
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [11:0] csrSel;
        rd = 5'($urandom_range(0, 31));
        if (rd == 5'd1) rd = 5'd0;
        r1 = 5'($urandom_range(0, 31));
        r2 = 5'($urandom_range(0, 31));
        imm = $urandom;
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 9: begin
                if (f3 == 3'd1) imm = {27'b0, imm[4:0]};
                if (f3 == 3'd5) imm = {20'b0, imm[31] ? 7'h20 : 7'h00, imm[4:0]};
                return encI(imm, r1, f3, rd, 7'h13);
            end
            1, 2: return encR(((f3 == 3'd0 || f3 == 3'd5) && imm[31]) ? 7'h20 : 7'h00, r2, r1, f3, rd, 7'h33);
            3: return encU(imm, rd, imm[31] ? 7'h37 : 7'h17);
            4: begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
                return encI(imm, 5'd1, f3, rd, 7'h03);
            end
            5: return encS(imm, r2, 5'd1, 3'($urandom_range(0, 2)));
            6: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
                return encB(imm[31] ? 32'd8 : 32'd12, r2, r1, f3);
            end
            7: begin
                if (f3 == 3'd0 || f3 == 3'd4) f3 = 3'd2;
                case ($urandom_range(0, 2))
                    0: csrSel = 12'h340; 1: csrSel = 12'h300; default: csrSel = 12'h7C0;
                endcase
                return encI({20'b0, csrSel}, r1, f3, rd, 7'h73);
            end
            default: return encJ(32'd8, rd);
        endcase
    endfunction

    initial begin
        // Control flow and trap round trip.
        clearMem();
        emit(encI(1, 0, 0, 3, 7'h13));
        emit(encI(32'h100, 0, 0, 9, 7'h13));
        emit(encI(32'h305, 9, 3'd1, 0, 7'h73));
        emit(encI(-1, 0, 0, 7, 7'h13));
        emit(encI(1, 0, 0, 8, 7'h13));
        emit(encB(8, 8, 7, 3'd4));
        emit(encI(99, 0, 0, 12, 7'h13));
        emit(encB(8, 8, 7, 3'd6));
        emit(encI(5, 0, 0, 13, 7'h13));
        emit(encJ(8, 1));
        emit(encI(77, 0, 0, 14, 7'h13));
        while (wp < 'h40) emit(32'h00000013);
        emit(32'h00000073);
        wp = 'h100;
        emit(32'h30200073);
        doReset();
        applyStimulus(1);
        checkOutput("first addi gp", dut.rs[3], 32'd1);
        checkOutput("first pc", dut.pc, 32'd4);
        applyStimulus(5);
        checkOutput("blt taken pc", dut.pc, 32'h1C);
        applyStimulus(1);
        checkOutput("bltu not taken pc", dut.pc, 32'h20);
        applyStimulus(2);
        checkOutput("jal pc", dut.pc, 32'h2C);
        checkOutput("jal link", dut.rs[1], 32'h28);
        checkOutput("skipped x12", dut.rs[12], 32'd0);
        checkOutput("executed x13", dut.rs[13], 32'd5);
        checkOutput("skipped x14", dut.rs[14], 32'd0);
        applyStimulus(6);
        checkOutput("ecall pc", dut.pc, 32'h100);
        checkOutput("mepc", dut.csr[12'h341], 32'h40);
        checkOutput("mcause", dut.csr[12'h342], 32'd11);
        applyStimulus(1);
        checkOutput("mret pc", dut.pc, 32'h40);

        // Loads, byte-lane stores, misalignment and address wrap.
        clearMem();
        mmem['h2000] = 8'hFF; mmem['h2001] = 8'h00; mmem['h2002] = 8'h00; mmem['h2003] = 8'hFF;
        mmem['hFFFE] = 8'h11; mmem['hFFFF] = 8'h22;
        emit(encU(2, 1, 7'h37));
        emit(encI(0, 1, 3'd1, 4, 7'h03));
        emit(encI(2, 1, 3'd1, 5, 7'h03));
        emit(encI(2, 1, 3'd5, 6, 7'h03));
        emit(encU(32'h12345, 2, 7'h37));
        emit(encI(32'h678, 2, 0, 2, 7'h13));
        emit(encS(0, 2, 1, 3'd2));
        emit(encS(1, 0, 1, 3'd0));
        emit(encI(0, 1, 3'd2, 10, 7'h03));
        emit(encI(1, 1, 3'd1, 11, 7'h03));
        emit(encU(32'h10, 15, 7'h37));
        emit(encI(-2, 15, 3'd2, 16, 7'h03));
        doReset();
        applyStimulus(12);
        checkOutput("lh +0", dut.rs[4], 32'h000000FF);
        checkOutput("lh +2", dut.rs[5], 32'hFFFFFF00);
        checkOutput("lhu +2", dut.rs[6], 32'h0000FF00);
        checkOutput("lw after sb", dut.rs[10], 32'h12340078);
        checkOutput("lh misaligned", dut.rs[11], 32'h00003400);
        checkOutput("lw wrap", dut.rs[16], 32'h20B72211);

        // Random programs around a data window at 0x3000.
        for (int r = 0; r < 4; r++) begin
            clearMem();
            for (int i = 'h2800; i < 'h3800; i++) mmem[i] = 8'($urandom_range(0, 255));
            emit(encU(3, 1, 7'h37));
            emit(encI(32'h340, 0, 3'd1, 0, 7'h73));
            emit(encI(32'h300, 0, 3'd1, 0, 7'h73));
            emit(encI(32'h7C0, 0, 3'd1, 0, 7'h73));
            for (int i = 0; i < 120; i++) emit(randomInstr());
            repeat (4) emit(encJ(0, 0));
            doReset();
            applyStimulus(130);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/core.md
# core

Single-cycle RV32I processor core with integrated 64 KiB byte-addressed unified memory, 32×32 register file and machine-mode CSR array. It is the top of the CPU design. It is built to run the riscv-tests `rv32ui-p-*` suites, whose benches preload memory and read the result from `x3` (gp). A test passes when gp == 1.

## Interface
- No parameters. Memory size is fixed at 65536 bytes.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-low reset; sampled on rising `clk`.
- No other ports. Benches observe state hierarchically and require these exact names:
  - `memory.m[0:65535]`: 8-bit array in sub-instance `memory`, preloadable via `$readmemh`.
  - `rs[0:31]`: 32-bit register file.
  - `csr[0:4095]`: 32-bit CSR array.

## Operation
- Fetch 32-bit little-endian instruction from `m[pc+0..pc+3]`. Decode, execute and write back in the same cycle.
- Executes all RV32I instructions:
  - LUI, AUIPC, JAL, JALR (target LSB cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU and SB/SH/SW.
  - All OP-IMM and OP ops; shift amount is the low 5 bits.
- Loads:
  - Little-endian, byte-granular reads, so misaligned accesses are permitted.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Stores write only the addressed 1/2/4 bytes.
- All addresses are truncated to 16 bits, so accesses wrap modulo 64 KiB.
- `rs[0]` always reads 0; writes to x0 are discarded.
- FENCE, FENCE.I and WFI execute as NOP (pc+4).
- CSR instructions:
  - CSRRW/RS/RC and CSRRWI/RSI/RCI read old `csr[addr]` into rd, then write the new value.
  - RS/RC with rs1/uimm = 0 perform no write.
  - The full 4096-entry array is plain read/write storage, so mhartid reads 0 unless written.
- ECALL (and EBREAK):
  - `csr[0x341]` mepc ← pc.
  - `csr[0x342]` mcause ← 11 (ECALL) or 3 (EBREAK).
  - pc ← `csr[0x305]` mtvec with bits [1:0] cleared.
- MRET: pc ← `csr[0x341]`.
- Unrecognised encodings execute as NOP (pc+4). No illegal-instruction trap.
- Next pc = branch/jump target if taken, else pc+4. pc is 32-bit; the fetch address is pc[15:0].

## Timing
- One instruction retires per `clk` rising edge. There are no stalls.
- Memory read (fetch and load data) is combinational. Memory write is synchronous on `clk`.
- Register-file and CSR writes are synchronous. Reads are combinational; a read in the same cycle as a write returns the old value.
- Reset (`rst` == 0 at rising edge):
  - pc ← 0.
  - All `rs` ← 0.
  - No memory or register writes are committed that cycle.
  - `csr` contents are not cleared, so preloaded state is retained; benches must not rely on CSR values before the program writes them.
  - Memory contents are never affected by reset.
- After `rst` returns high, the first fetch is from address 0 in that cycle.
- Reset asserted mid-program aborts the in-flight instruction with no side effects.

## Structure
- Shared package `core_pkg` holds:
  - Opcode constants (LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC, SYSTEM, MISC_MEM).
  - funct3/funct7 constants.
  - CSR addresses MTVEC=0x305, MEPC=0x341, MCAUSE=0x342.
- One sub-module `memory`, instance name `memory`:
  - Byte array `m`.
  - Ports: combinational 32-bit fetch read, combinational 32-bit data read, synchronous byte-enabled data write.
- Decode, ALU, register file and CSR logic stay in `core`.

## Test plan
- Reset/fetch:
  - Hold `rst`=0 for two cycles, then release with `m[0..3]` = ADDI x3,x0,1 (0x00100193).
  - Required: `rs[3]`==1 after one cycle and pc==4.
- LH sign extension:
  - Preload bytes 0x2000..0x2003 = FF 00 00 FF and set x1=0x2000.
  - LH x4,0(x1) → 0x000000FF.
  - LH x5,2(x1) → 0xFFFFFF00.
  - LHU x6,2(x1) → 0x0000FF00.
- Store/load byte lanes:
  - With x2=0x12345678, run SW then SB x0,1(x1).
  - LW → 0x12340078.
  - Misaligned LH at x1+1 → 0x00003400.
- Branch/jump:
  - BLT x7,x8 with x7=-1, x8=1 is taken.
  - BLTU with the same operands is not taken.
  - JAL x1,+8 writes pc+4 into x1 and sets pc+8.
- Trap round trip:
  - CSRRW x0,mtvec,x9 with x9=0x100, then ECALL at 0x40.
  - Required: mepc==0x40, mcause==11, pc==0x100.
  - MRET at 0x100 sets pc==0x40.
- Full suite: each `rv32ui-p-*` hex (lh, lw, sb, add, …) run 5000 cycles from reset → `rs[3]`==1.
